// File: rtl/quad_dec_pkg.sv
// Shared quadrature state encodings and the Gray-code transition decoder.
// States are packed as {A, B}.
package quad_dec_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_10 = 2'b10;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_01 = 2'b01;

  typedef enum logic [1:0] {
    QD_NONE = 2'd0,
    QD_UP   = 2'd1,
    QD_DN   = 2'd2,
    QD_ERR  = 2'd3
  } qd_res_e;

  // Forward (A leads) successor of a quadrature state: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] qs_next_up(input logic [1:0] s);
    logic [1:0] n;
    n = QS_10;
    case (s)
      QS_00: n = QS_10;
      QS_10: n = QS_11;
      QS_11: n = QS_01;
      QS_01: n = QS_00;
      default: n = QS_10;
    endcase
    return n;
  endfunction

  function automatic qd_res_e qd_decode(input logic [1:0] prev, input logic [1:0] cur);
    qd_res_e r;
    if (prev == cur)
      r = QD_NONE;
    else if ((prev ^ cur) == 2'b11)
      r = QD_ERR;
    else if (qs_next_up(prev) == cur)
      r = QD_UP;
    else
      r = QD_DN;
    return r;
  endfunction

endpackage

// File: rtl/quad_sync_filt.sv
// One encoder channel: multi-flop synchronizer, plus a stability filter when
// QDEC_GLITCH_FILTER_EN is defined.
module quad_sync_filt #(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILTER_EN
  , parameter int FILT_LEN  = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync_q <= '0;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // The filtered level moves only after FILT_LEN back-to-back samples that
  // disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_q <= sync_out;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_out;
`endif

endmodule

// File: rtl/quad_dec_cntr.sv
// Quadrature decoder with wrap-around up/down position counter.
// Optional glitch filter on both channels: QDEC_GLITCH_FILTER_EN.
module quad_dec_cntr
  import quad_dec_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err
);

`ifdef QDEC_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  // Priming covers the pipeline fill so reset release never decodes stale zeros.
  localparam int PRIME_LEN = SYNC_STAGES + 1 + (FILT_ON ? FILT_LEN : 0);
  localparam int PW        = $clog2(PRIME_LEN + 1);
  localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_LEN);

  logic          a_s, b_s;
  logic [1:0]    cur, prev_q;
  logic [PW-1:0] prime_q;
  logic          primed;
  qd_res_e       res;

  quad_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    , .FILT_LEN (FILT_LEN)
`endif
  ) u_sync_a (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (a_in),
    .dout (a_s)
  );

  quad_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_GLITCH_FILTER_EN
    , .FILT_LEN (FILT_LEN)
`endif
  ) u_sync_b (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (b_in),
    .dout (b_s)
  );

  assign cur    = {a_s, b_s};
  assign primed = (prime_q == PRIME_DONE);
  assign res    = qd_decode(prev_q, cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= QS_00;
      prime_q <= '0;
      pos     <= '0;
      dir     <= 1'b1;
      step    <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev_q <= cur;
      step   <= 1'b0;
      if (!primed)
        prime_q <= prime_q + 1'b1;

      // clr wins over any transition decoded this cycle; that transition is dropped.
      if (clr) begin
        pos <= '0;
        err <= 1'b0;
      end else if (primed) begin
        case (res)
          QD_UP: if (en) begin
            pos  <= pos + 1'b1;
            dir  <= 1'b1;
            step <= 1'b1;
          end
          QD_DN: if (en) begin
            pos  <= pos - 1'b1;
            dir  <= 1'b0;
            step <= 1'b1;
          end
          QD_ERR:  err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_dec_cntr.sv
// Directed bench for quad_dec_cntr: reset, priming, counting, wrap, err/clr,
// clr priority, glitch handling, enable gating and mid-run reset.
module tb_quad_dec_cntr;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_in = 1'b1;
  logic        b_in = 1'b1;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] pos;
  logic        dir, step, err;

  int vectors = 0;
  int miscompares = 0;
  int step_cnt = 0;
  int base;

  quad_dec_cntr dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a_in (a_in),
    .b_in (b_in),
    .en   (en),
    .clr  (clr),
    .pos  (pos),
    .dir  (dir),
    .step (step),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step) step_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read on falling edges.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic move(input logic a, input logic b);
    a_in = a;
    b_in = b;
    edges(HOLD);
  endtask

  // Move and verify step is low one cycle early and high exactly LAT edges later.
  task automatic move_lat(input logic a, input logic b, input string tag);
    a_in = a;
    b_in = b;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check({tag, "_step_early"}, {31'd0, step}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_step_on_time"}, {31'd0, step}, 32'd1);
    edges(HOLD - LAT);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    edges(1);
    clr = 1'b0;
    edges(1);
  endtask

  initial begin
    // Reset with both channels high.
    edges(3);
    @(negedge clk);
    check("rst_pos", {16'd0, pos}, 32'h0);
    check("rst_dir", {31'd0, dir}, 32'd1);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = step_cnt;
    edges(10);
    @(negedge clk);
    check("prime_pos", {16'd0, pos}, 32'h0);
    check("prime_steps", step_cnt - base, 32'd0);
    check("prime_err", {31'd0, err}, 32'd0);
    edges(1);

    // Eight forward transitions starting from 11.
    base = step_cnt;
    move_lat(1'b0, 1'b1, "fwd1");
    move(1'b0, 1'b0);
    move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);
    move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    check("fwd_pos", {16'd0, pos}, 32'h0008);
    check("fwd_dir", {31'd0, dir}, 32'd1);
    check("fwd_steps", step_cnt - base, 32'd8);

    // Reach state 00 then clear to zero; wrap down and back up.
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);
    check("fwd10_pos", {16'd0, pos}, 32'h000A);
    pulse_clr();
    check("clr_pos", {16'd0, pos}, 32'h0);
    move(1'b0, 1'b1);
    check("wrap_dn_pos", {16'd0, pos}, 32'hFFFF);
    check("wrap_dn_dir", {31'd0, dir}, 32'd0);
    move(1'b0, 1'b0);
    check("wrap_up_pos", {16'd0, pos}, 32'h0000);
    check("wrap_up_dir", {31'd0, dir}, 32'd1);

    // Illegal jump 00 -> 11.
    base = step_cnt;
    a_in = 1'b1;
    b_in = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_pos", {16'd0, pos}, 32'h0);
    edges(HOLD);
    check("ill_steps", step_cnt - base, 32'd0);
    check("ill_err_sticky", {31'd0, err}, 32'd1);
    pulse_clr();
    check("ill_clr_err", {31'd0, err}, 32'd0);
    check("ill_clr_pos", {16'd0, pos}, 32'h0);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);
    check("post_clr_pos", {16'd0, pos}, 32'h0002);
    check("post_clr_err", {31'd0, err}, 32'd0);

    // clr coinciding with a decoded up transition at pos 5.
    move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    move(1'b0, 1'b1);
    check("pre_coinc_pos", {16'd0, pos}, 32'h0005);
    base = step_cnt;
    a_in = 1'b0;
    b_in = 1'b0;
    edges(LAT - 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("coinc_pos", {16'd0, pos}, 32'h0);
    check("coinc_step", {31'd0, step}, 32'd0);
    edges(HOLD);
    check("coinc_steps", step_cnt - base, 32'd0);
    move(1'b1, 1'b0);
    check("after_coinc_pos", {16'd0, pos}, 32'h0001);
    check("after_coinc_dir", {31'd0, dir}, 32'd1);

    // Return to 00 (down), then a one-clock high glitch on A.
    move(1'b0, 1'b0);
    check("pre_glitch_pos", {16'd0, pos}, 32'h0);
    base = step_cnt;
    a_in = 1'b1;
    edges(1);
    a_in = 1'b0;
    edges(12);
    check("glitch_pos", {16'd0, pos}, 32'h0);
    check("glitch_dir", {31'd0, dir}, 32'd0);
    check("glitch_err", {31'd0, err}, 32'd0);
`ifdef QDEC_GLITCH_FILTER_EN
    check("glitch_steps", step_cnt - base, 32'd0);
`else
    check("glitch_steps", step_cnt - base, 32'd2);
`endif

    // Forward sweep with en low: frozen; re-enable gives no spurious step.
    en = 1'b0;
    base = step_cnt;
    move(1'b1, 1'b0);
    move(1'b1, 1'b1);
    move(1'b0, 1'b1);
    move(1'b0, 1'b0);
    check("en0_pos", {16'd0, pos}, 32'h0);
    check("en0_dir", {31'd0, dir}, 32'd0);
    check("en0_steps", step_cnt - base, 32'd0);
    en = 1'b1;
    edges(4);
    check("reen_steps", step_cnt - base, 32'd0);
    move(1'b1, 1'b0);
    check("reen_pos", {16'd0, pos}, 32'h0001);
    check("reen_dir", {31'd0, dir}, 32'd1);
    check("reen_steps_one", step_cnt - base, 32'd1);

    // Mid-run reset clears at once and re-primes with A=1, B=0 held.
    move(1'b0, 1'b0);
    move(1'b0, 1'b1);
    check("pre_rst_pos", {16'd0, pos}, 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pos", {16'd0, pos}, 32'h0);
    check("mid_rst_dir", {31'd0, dir}, 32'd1);
    a_in = 1'b1;
    b_in = 1'b0;
    edges(2);
    rst_n = 1'b1;
    base = step_cnt;
    edges(12);
    check("re_prime_pos", {16'd0, pos}, 32'h0);
    check("re_prime_steps", step_cnt - base, 32'd0);
    check("re_prime_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
